// File: rtl/flp_norm_pkg.sv
// Shared definitions for the flp blocks: FP32 width constants and the
// normaliser state encoding.
package flp_norm_pkg;

  localparam int FP32_EWIDTH  = 8;
  localparam int FP32_SWIDTH  = 23;
  localparam int FP32_RSWIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } flp_state_e;

endpackage

// File: rtl/flp_norm_if.sv
// Operand/result handshake bundle for flp_norm. The slave modport is the
// normaliser, the master modport is whoever feeds it and drains results.
interface flp_norm_if
  import flp_norm_pkg::*;
#(
  parameter int EWIDTH  = FP32_EWIDTH,
  parameter int SWIDTH  = FP32_SWIDTH,
  parameter int RSWIDTH = FP32_RSWIDTH
);
  logic                        i_valid;
  logic                        o_ready;
  logic                        i_sign;
  logic [EWIDTH-1:0]           i_ex;
  logic [SWIDTH+RSWIDTH+1:0]   i_sg;
  logic                        o_valid;
  logic                        i_ready;
  logic                        o_sign;
  logic [EWIDTH-1:0]           o_ex;
  logic [SWIDTH-1:0]           o_sg;
  logic                        o_zero;
  logic                        o_ovf;

  modport slave (
    input  i_valid, i_sign, i_ex, i_sg, i_ready,
    output o_ready, o_valid, o_sign, o_ex, o_sg, o_zero, o_ovf
  );

  modport master (
    output i_valid, i_sign, i_ex, i_sg, i_ready,
    input  o_ready, o_valid, o_sign, o_ex, o_sg, o_zero, o_ovf
  );
endinterface

// File: rtl/flp_rne_round.sv
// Combinational rounding of a normalised significand (hidden bit downwards).
// Define FLP_NORM_ROUND_EN for round-to-nearest-even; otherwise truncate.
module flp_rne_round
  import flp_norm_pkg::*;
#(
  parameter int EWIDTH  = FP32_EWIDTH,
  parameter int SWIDTH  = FP32_SWIDTH,
  parameter int RSWIDTH = FP32_RSWIDTH
) (
  input  logic [SWIDTH+RSWIDTH:0] sig,
  input  logic [EWIDTH-1:0]       ex,
  output logic [EWIDTH-1:0]       rnd_ex,
  output logic [SWIDTH-1:0]       rnd_sg
);

`ifdef FLP_NORM_ROUND_EN
  logic [SWIDTH:0]   mant;
  logic              guard_bit;
  logic              sticky_bit;
  logic              inc;
  logic [SWIDTH+1:0] sum;

  assign mant       = sig[SWIDTH+RSWIDTH:RSWIDTH];
  assign guard_bit  = sig[RSWIDTH-1];
  assign sticky_bit = |sig[RSWIDTH-2:0];
  // Ties go to the even significand: only round up on a tie when LSB is odd.
  assign inc        = guard_bit & (sticky_bit | mant[0]);
  assign sum        = {1'b0, mant} + (SWIDTH+2)'(inc);

  always_comb begin
    if (sum[SWIDTH+1]) begin
      rnd_sg = sum[SWIDTH:1];
      rnd_ex = ex + EWIDTH'(1);
    end else begin
      rnd_sg = sum[SWIDTH-1:0];
      rnd_ex = ex;
    end
  end
`else
  logic unused_bits;

  assign rnd_sg      = sig[RSWIDTH +: SWIDTH];
  assign rnd_ex      = ex;
  assign unused_bits = ^{sig[SWIDTH+RSWIDTH], sig[RSWIDTH-1:0]};
`endif

endmodule

// File: rtl/flp_norm.sv
// Floating-point post-add normaliser: one-bit-per-cycle left shift, carry
// correction, rounding and overflow-to-infinity. Rounding mode set by
// FLP_NORM_ROUND_EN (see flp_rne_round).
module flp_norm
  import flp_norm_pkg::*;
#(
  parameter int EWIDTH  = FP32_EWIDTH,
  parameter int SWIDTH  = FP32_SWIDTH,
  parameter int RSWIDTH = FP32_RSWIDTH
) (
  input logic       clk,
  input logic       rst,
  flp_norm_if.slave bus
);

  localparam int W = SWIDTH + RSWIDTH + 2;

  flp_state_e        state_q, state_d;
  logic [W-1:0]      sig_q, sig_d;
  logic [EWIDTH-1:0] ex_q, ex_d;
  logic              sign_q, sign_d;

  logic              res_sign_q, res_sign_d;
  logic [EWIDTH-1:0] res_ex_q, res_ex_d;
  logic [SWIDTH-1:0] res_sg_q, res_sg_d;
  logic              res_zero_q, res_zero_d;
  logic              res_ovf_q, res_ovf_d;

  logic [EWIDTH-1:0] rnd_ex;
  logic [SWIDTH-1:0] rnd_sg;

  flp_rne_round #(
    .EWIDTH (EWIDTH),
    .SWIDTH (SWIDTH),
    .RSWIDTH(RSWIDTH)
  ) u_round (
    .sig   (sig_q[W-2:0]),
    .ex    (ex_q),
    .rnd_ex(rnd_ex),
    .rnd_sg(rnd_sg)
  );

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_sign  = res_sign_q;
  assign bus.o_ex    = res_ex_q;
  assign bus.o_sg    = res_sg_q;
  assign bus.o_zero  = res_zero_q;
  assign bus.o_ovf   = res_ovf_q;

  always_comb begin
    // NOTE: every variable gets a hold value first so no path infers a latch.
    state_d    = state_q;
    sig_d      = sig_q;
    ex_d       = ex_q;
    sign_d     = sign_q;
    res_sign_d = res_sign_q;
    res_ex_d   = res_ex_q;
    res_sg_d   = res_sg_q;
    res_zero_d = res_zero_q;
    res_ovf_d  = res_ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          sig_d   = bus.i_sg;
          ex_d    = bus.i_ex;
          sign_d  = bus.i_sign;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (sig_q[W-1]) begin
          // Right shift keeps the dropped bit alive in the sticky position.
          sig_d   = {1'b0, sig_q[W-1:2], sig_q[1] | sig_q[0]};
          ex_d    = (ex_q == '1) ? ex_q : ex_q + EWIDTH'(1);
          state_d = ST_ROUND;
        end else if (sig_q == '0) begin
          ex_d       = '0;
          res_sign_d = sign_q;
          res_ex_d   = '0;
          res_sg_d   = '0;
          res_zero_d = 1'b1;
          res_ovf_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (sig_q[W-2]) begin
          state_d = ST_ROUND;
        end else if (ex_q <= EWIDTH'(1)) begin
          ex_d    = '0;
          state_d = ST_ROUND;
        end else begin
          sig_d = sig_q << 1;
          ex_d  = ex_q - EWIDTH'(1);
        end
      end

      ST_ROUND: begin
        res_sign_d = sign_q;
        res_zero_d = 1'b0;
        if ((ex_q == '1) || (rnd_ex == '1)) begin
          res_ex_d  = '1;
          res_sg_d  = '0;
          res_ovf_d = 1'b1;
        end else begin
          res_ex_d  = rnd_ex;
          res_sg_d  = rnd_sg;
          res_ovf_d = 1'b0;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state lives only here and uses <=, so every register sees the
  // pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working registers are cleared too; with no reset they would
      // still be correct (reloaded on accept) but simulate as X until then.
      state_q    <= ST_IDLE;
      sig_q      <= '0;
      ex_q       <= '0;
      sign_q     <= 1'b0;
      res_sign_q <= 1'b0;
      res_ex_q   <= '0;
      res_sg_q   <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      ex_q       <= ex_d;
      sign_q     <= sign_d;
      res_sign_q <= res_sign_d;
      res_ex_q   <= res_ex_d;
      res_sg_q   <= res_sg_d;
      res_zero_q <= res_zero_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_flp_norm.sv
// Directed-vector bench for flp_norm at FP32 widths; expectations for the
// rounding vectors follow FLP_NORM_ROUND_EN.
module tb_flp_norm;
  import flp_norm_pkg::*;

`ifdef FLP_NORM_ROUND_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  flp_norm_if #(.EWIDTH(8), .SWIDTH(23), .RSWIDTH(2)) bus ();

  flp_norm #(.EWIDTH(8), .SWIDTH(23), .RSWIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operand through the block; hold = cycles of back-pressure in DONE.
  task automatic run_op(input string name, input logic sign, input logic [7:0] ex,
                        input logic [26:0] sg, input int lat, input logic [7:0] e_ex,
                        input logic [22:0] e_sg, input logic e_zero, input logic e_ovf,
                        input int hold);
    int n;
    @(negedge clk);
    check({name, ".ready"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_sign  = sign;
    bus.i_ex    = ex;
    bus.i_sg    = sg;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sign  = ~sign;
    bus.i_ex    = 8'h55;
    bus.i_sg    = 27'h5A5A5A5;
    check({name, ".early"}, 32'(bus.o_valid), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.o_valid && n < 60);
    check({name, ".latency"}, 32'(n), 32'(lat));
    check({name, ".sign"}, 32'(bus.o_sign), 32'(sign));
    check({name, ".ex"}, 32'(bus.o_ex), 32'(e_ex));
    check({name, ".sg"}, 32'(bus.o_sg), 32'(e_sg));
    check({name, ".zero"}, 32'(bus.o_zero), 32'(e_zero));
    check({name, ".ovf"}, 32'(bus.o_ovf), 32'(e_ovf));
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      check({name, ".hold_valid"}, 32'(bus.o_valid), 32'd1);
      check({name, ".hold_ready"}, 32'(bus.o_ready), 32'd0);
      check({name, ".hold_ex"}, 32'(bus.o_ex), 32'(e_ex));
      check({name, ".hold_sg"}, 32'(bus.o_sg), 32'(e_sg));
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({name, ".release_valid"}, 32'(bus.o_valid), 32'd0);
    check({name, ".release_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    int seen;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_ex    = '0;
    bus.i_sg    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 32'(bus.o_valid), 32'd0);
    check("reset.ready", 32'(bus.o_ready), 32'd1);
    check("reset.ex", 32'(bus.o_ex), 32'd0);
    check("reset.sg", 32'(bus.o_sg), 32'd0);
    check("reset.flags", 32'({bus.o_sign, bus.o_zero, bus.o_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("hidden",     1'b0, 8'h7F, 27'h2000000, 2, 8'h7F, 23'h000000, 1'b0, 1'b0, 0);
    run_op("carry",      1'b0, 8'h80, 27'h4000000, 2, 8'h81, 23'h000000, 1'b0, 1'b0, 0);
    run_op("lshift2",    1'b1, 8'h85, 27'h0800000, 4, 8'h83, 23'h000000, 1'b0, 1'b0, 0);
    run_op("round_up",   1'b0, 8'h7F, 27'h3FFFFFE, 2, RNE ? 8'h80 : 8'h7F,
           RNE ? 23'h000000 : 23'h7FFFFF, 1'b0, 1'b0, 0);
    run_op("zero",       1'b1, 8'h90, 27'h0000000, 1, 8'h00, 23'h000000, 1'b1, 1'b0, 0);
    run_op("ovf_carry",  1'b0, 8'hFE, 27'h4000000, 2, 8'hFF, 23'h000000, 1'b0, 1'b1, 0);
    run_op("tie_even",   1'b0, 8'h70, 27'h2000002, 2, 8'h70, 23'h000000, 1'b0, 1'b0, 0);
    run_op("tie_odd",    1'b1, 8'h70, 27'h2000006, 2, 8'h70,
           RNE ? 23'h000002 : 23'h000001, 1'b0, 1'b0, 5);
    run_op("above_half", 1'b0, 8'h70, 27'h2000003, 2, 8'h70,
           RNE ? 23'h000001 : 23'h000000, 1'b0, 1'b0, 0);
    run_op("sticky",     1'b0, 8'h80, 27'h4000005, 2, 8'h81,
           RNE ? 23'h000001 : 23'h000000, 1'b0, 1'b0, 0);
    run_op("denorm",     1'b0, 8'h01, 27'h0000004, 2, 8'h00, 23'h000001, 1'b0, 1'b0, 0);
    run_op("to_denorm",  1'b1, 8'h02, 27'h0800000, 3, 8'h00, 23'h400000, 1'b0, 1'b0, 0);
    run_op("ovf_round",  1'b0, 8'hFE, 27'h3FFFFFE, 2, RNE ? 8'hFF : 8'hFE,
           RNE ? 23'h000000 : 23'h7FFFFF, 1'b0, RNE, 0);

    // Reset while the operand is still being shifted in NORM.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_ex    = 8'h85;
    bus.i_sg    = 27'h0800000;
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.ready", 32'(bus.o_ready), 32'd1);
    check("midrst.valid", 32'(bus.o_valid), 32'd0);
    check("midrst.ex", 32'(bus.o_ex), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen++;
    end
    check("midrst.no_valid", 32'(seen), 32'd0);
    check("midrst.idle", 32'(bus.o_ready), 32'd1);

    run_op("after_rst",  1'b0, 8'h80, 27'h4000000, 2, 8'h81, 23'h000000, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
